// File: rtl/dt1_trace_pkg.sv
// Shared types for the dt1 retirement-trace path.
// One packed record per retired instruction, order field in the MSBs.
package dt1_trace_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } trace_rec_t;

  localparam int TRC_W = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO built on a register array; the head entry is read straight
// from storage so it only changes on a clock edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rvfi_trace_fifo.sv
// Buffers RVFI retirement records for a trace sink and tracks order/x0
// consistency plus dropped-record statistics.
module rvfi_trace_fifo
  import dt1_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rvfi_valid,
  input  logic [63:0]      rvfi_order,
  input  logic [31:0]      rvfi_insn,
  input  logic             rvfi_trap,
  input  logic [31:0]      rvfi_pc_rdata,
  input  logic [31:0]      rvfi_pc_wdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [TRC_W-1:0] trc_rec,
  output logic [AW:0]      count,
  input  logic             flush,
  input  logic             clr_flags,
  output logic             overflow,
  output logic             order_err,
  output logic             rd_err,
  output logic [15:0]      drop_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  trace_rec_t rec_in;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       drop;
  logic       order_bad;
  logic       x0_bad;
  logic       seen_first;
  logic [63:0] exp_order;

  always_comb begin
    rec_in          = '0;
    rec_in.order    = rvfi_order;
    rec_in.insn     = rvfi_insn;
    rec_in.trap     = rvfi_trap;
    rec_in.pc_rdata = rvfi_pc_rdata;
    rec_in.pc_wdata = rvfi_pc_wdata;
    rec_in.rd_addr  = rvfi_rd_addr;
    rec_in.rd_wdata = rvfi_rd_wdata;
  end

  // A full FIFO still accepts when the sink drains the head this same cycle.
  assign trc_valid = !empty;
  assign pop       = trc_valid && trc_ready;
  assign push      = rvfi_valid && (!full || pop);
  assign drop      = rvfi_valid && full && !pop && !flush;
  assign order_bad = rvfi_valid && seen_first && (rvfi_order != exp_order);
  assign x0_bad    = rvfi_valid && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);

  sync_fifo #(
    .WIDTH (TRC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (trc_rec),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Order tracking survives flush; a new set condition beats clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_first <= 1'b0;
      exp_order  <= '0;
      overflow   <= 1'b0;
      order_err  <= 1'b0;
      rd_err     <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (rvfi_valid) begin
        seen_first <= 1'b1;
        exp_order  <= rvfi_order + 64'd1;
      end
      if (clr_flags) begin
        overflow  <= drop;
        order_err <= order_bad;
        rd_err    <= x0_bad;
        drop_cnt  <= drop ? 16'd1 : 16'd0;
      end else begin
        overflow  <= overflow  | drop;
        order_err <= order_err | order_bad;
        rd_err    <= rd_err    | x0_bad;
        if (drop) drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

endmodule
